freq_display: RTL and testbench

FREQ_DISPLAY -- requirements
Module: freq_display

---
 rtl/freq_pkg.sv | 26 ++
 rtl/freq_display_if.sv | 14 +
 rtl/bin2bcd_seq.sv | 69 ++++++
 rtl/freq_display.sv | 96 +++++++++
 tb/tb_freq_display.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/freq_pkg.sv
// Shared types and constants for the frequency display: FSM states,
// active-low seven-segment codes and the digit count.
package freq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_t;

  localparam int NUM_DIGITS = 8;
  localparam int BIN_W      = 20;
  localparam int BCD_W      = 28;

  // Bit order is {g,f,e,d,c,b,a}; a segment is lit when its bit is 0.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_CODE [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    return (d > 4'd9) ? SEG_BLANK : SEG_CODE[d];
  endfunction

endpackage

// File: rtl/freq_display_if.sv
// Bundle of the frequency display's data and display-drive signals, so a
// driving environment can hold them as one object.
interface freq_display_if;
  import freq_pkg::*;

  logic [BIN_W-1:0]      frequency;
  logic [NUM_DIGITS-1:0] AN;
  logic [6:0]            SEG;
  logic                  DP;
  logic                  busy;

  modport master (output frequency, input AN, SEG, DP, busy);
  modport slave  (input frequency, output AN, SEG, DP, busy);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: 20-bit binary to seven BCD nibbles,
// one shift per clock, result presented during the single LOAD clock.
module bin2bcd_seq
  import freq_pkg::*;
(
  input  logic             clock,
  input  logic             reset,   // asynchronous, active low
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic [BCD_W-1:0] bcd,
  output logic             busy,
  output logic             done
);

  // Handshake: start is sampled only in IDLE and captures bin on that edge;
  // busy is high from the next clock until done, which pulses for one clock
  // while bcd holds the finished result.
  state_t      state_q, state_d;
  logic [47:0] sr_q, sr_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [27:0] adj;

  always_comb begin
    adj = '0;
    for (int i = 0; i < 7; i++) begin
      adj[4*i +: 4] = (sr_q[BIN_W+4*i +: 4] >= 4'd5) ? sr_q[BIN_W+4*i +: 4] + 4'd3
                                                     : sr_q[BIN_W+4*i +: 4];
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          sr_d    = {28'b0, bin};
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        sr_d  = {adj, sr_q[BIN_W-1:0]} << 1;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd19) state_d = LOAD;
      end
      LOAD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bcd  = sr_q[47:BIN_W];
  assign busy = (state_q != IDLE);
  assign done = (state_q == LOAD);

endmodule

// File: rtl/freq_display.sv
// Eight-digit multiplexed display of a 20-bit frequency: change detection,
// BCD conversion, atomic digit update, leading-zero blanking and scanning.
module freq_display
  import freq_pkg::*;
#(
  parameter int REFRESH_BITS = 17
) (
  input  logic                  CLK100MHZ,
  input  logic                  CPU_RESETN,
  input  logic [BIN_W-1:0]      frequency,
  output logic [NUM_DIGITS-1:0] AN,
  output logic [6:0]            SEG,
  output logic                  DP,
  output logic                  busy
);

  localparam int SCAN_W = REFRESH_BITS + 3;

  logic [BIN_W-1:0]      freq_q, freq_d;
  logic                  pending_q, pending_d;
  logic [BCD_W-1:0]      digits_q, digits_d;
  logic [SCAN_W-1:0]     scan_q, scan_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;

  logic             changed, conv_start, conv_busy, conv_done;
  logic [BCD_W-1:0] conv_bcd;
  logic [2:0]       sel;
  logic [31:0]      digits_ext;
  logic [NUM_DIGITS-1:0] show;
  logic             lead;
  logic [3:0]       nib;

  assign changed    = (frequency != freq_q);
  assign conv_start = changed | pending_q;

  bin2bcd_seq u_conv (
    .clock (CLK100MHZ),
    .reset (CPU_RESETN),
    .start (conv_start),
    .bin   (frequency),
    .bcd   (conv_bcd),
    .busy  (conv_busy),
    .done  (conv_done)
  );

  // A change seen mid-conversion is remembered; the flag drops once the
  // converter is back in IDLE, where conv_start is always accepted.
  always_comb begin
    freq_d    = frequency;
    pending_d = conv_busy & (pending_q | changed);
    digits_d  = conv_done ? conv_bcd : digits_q;
    scan_d    = scan_q + 1'b1;
  end

  assign sel = scan_q[SCAN_W-1 -: 3];

  // Walk from the top digit down; a digit is shown once any digit at or
  // above it is nonzero, and digit 0 is always shown.
  always_comb begin
    digits_ext = {4'h0, digits_q};
    lead       = 1'b1;
    show       = '0;
    for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
      if (digits_ext[4*i +: 4] != 4'd0) lead = 1'b0;
      show[i] = ~lead | (i == 0);
    end
    nib   = digits_ext[4*sel +: 4];
    an_d  = ~(8'b1 << sel);
    seg_d = show[sel] ? seg_encode(nib) : SEG_BLANK;
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      freq_q    <= '0;
      pending_q <= 1'b0;
      digits_q  <= '0;
      scan_q    <= '0;
      an_q      <= '1;
      seg_q     <= SEG_BLANK;
    end else begin
      freq_q    <= freq_d;
      pending_q <= pending_d;
      digits_q  <= digits_d;
      scan_q    <= scan_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  assign AN   = an_q;
  assign SEG  = seg_q;
  assign DP   = 1'b1;
  assign busy = conv_busy;

endmodule

// File: tb/tb_freq_display.sv
// Directed bench for freq_display with a short scan period (REFRESH_BITS=2).
module tb_freq_display;

  localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30,
                         S4 = 7'h19, S5 = 7'h12, S6 = 7'h02, S7 = 7'h78,
                         S8 = 7'h00, S9 = 7'h10, BL = 7'h7F;

  typedef struct {
    logic [19:0] freq;
    logic [55:0] segs;  // {digit7, ..., digit0}
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  freq_display_if dif ();

  freq_display #(.REFRESH_BITS(2)) dut (
    .CLK100MHZ  (clk),
    .CPU_RESETN (rst_n),
    .frequency  (dif.frequency),
    .AN         (dif.AN),
    .SEG        (dif.SEG),
    .DP         (dif.DP),
    .busy       (dif.busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (dif.busy && n < 40) begin
      tick();
      n++;
    end
    check($sformatf("%s idle", name), dif.busy, 1'b0);
  endtask

  // Observe one full scan (32 clocks) and compare every digit.
  task automatic capture(input string name, input logic [55:0] exp);
    logic [6:0] cap [8];
    logic [7:0] seen;
    int bad_an;
    seen   = '0;
    bad_an = 0;
    for (int d = 0; d < 8; d++) cap[d] = 7'h55;
    for (int k = 0; k < 32; k++) begin
      tick();
      if ($countones(~dif.AN) != 1) bad_an++;
      else begin
        for (int d = 0; d < 8; d++) begin
          if (!dif.AN[d]) begin
            cap[d]  = dif.SEG;
            seen[d] = 1'b1;
          end
        end
      end
    end
    check($sformatf("%s one_anode", name), bad_an, 0);
    check($sformatf("%s all_digits", name), seen, 8'hFF);
    for (int d = 0; d < 8; d++)
      check($sformatf("%s d%0d", name, d), cap[d], exp[7*d +: 7]);
  endtask

  task automatic apply_and_show(input string name, input logic [19:0] f, input logic [55:0] exp);
    dif.frequency = f;
    for (int k = 0; k < 25; k++) tick();
    capture(name, exp);
  endtask

  vec_t        vecs [8];
  logic [7:0]  exp_an;
  logic [55:0] v5000;
  int          busy_seen;
  int          idx;

  initial begin
    rst_n         = 1'b0;
    dif.frequency = 20'd0;

    vecs[0] = '{20'd5,       {BL, BL, BL, BL, BL, BL, BL, S5}};
    vecs[1] = '{20'd90,      {BL, BL, BL, BL, BL, BL, S9, S0}};
    vecs[2] = '{20'd800,     {BL, BL, BL, BL, BL, S8, S0, S0}};
    vecs[3] = '{20'd100000,  {BL, BL, S1, S0, S0, S0, S0, S0}};
    vecs[4] = '{20'd654321,  {BL, BL, S6, S5, S4, S3, S2, S1}};
    vecs[5] = '{20'd999999,  {BL, BL, S9, S9, S9, S9, S9, S9}};
    vecs[6] = '{20'd1048575, {BL, S1, S0, S4, S8, S5, S7, S5}};
    vecs[7] = '{20'd0,       {BL, BL, BL, BL, BL, BL, BL, S0}};
    v5000   = {BL, BL, BL, BL, S5, S0, S0, S0};

    // Reset values.
    repeat (3) tick();
    check("rst AN", dif.AN, 8'hFF);
    check("rst SEG", dif.SEG, 7'h7F);
    check("rst DP", dif.DP, 1'b1);
    check("rst busy", dif.busy, 1'b0);

    // Release with frequency 0: anode walk, 4 clocks per digit, wrap 7->0.
    rst_n     = 1'b1;
    busy_seen = 0;
    for (int k = 0; k <= 32; k++) begin
      tick();
      exp_an = ~(8'd1 << ((k / 4) % 8));
      check($sformatf("scan k%0d", k), dif.AN, exp_an);
      if (dif.busy) busy_seen++;
    end
    check("idle after reset busy", busy_seen, 0);
    capture("zero", {BL, BL, BL, BL, BL, BL, BL, S0});

    // 0 -> 123000: busy for exactly 21 clocks, then the new value.
    dif.frequency = 20'd123000;
    for (int k = 1; k <= 22; k++) begin
      tick();
      check($sformatf("busy123 k%0d", k), dif.busy, (k <= 21));
    end
    capture("v123000", {BL, BL, S1, S2, S3, S0, S0, S0});

    for (int i = 0; i < 8; i++)
      apply_and_show($sformatf("vec%0d", i), vecs[i].freq, vecs[i].segs);

    // 5000, then 9000 arriving ten clocks into the conversion.
    dif.frequency = 20'd5000;
    tick();
    check("p busy rise", dif.busy, 1'b1);
    repeat (10) tick();
    dif.frequency = 20'd9000;
    wait_idle("p first");
    tick();
    check("p restart", dif.busy, 1'b1);
    for (int k = 0; k < 19; k++) begin
      tick();
      idx = 0;
      for (int d = 0; d < 8; d++) if (!dif.AN[d]) idx = d;
      check($sformatf("hold5000 c%0d", k), dif.SEG, v5000[7*idx +: 7]);
    end
    wait_idle("p second");
    repeat (2) tick();
    capture("v9000", {BL, BL, BL, BL, S9, S0, S0, S0});

    // Reset in the middle of a conversion.
    apply_and_show("v777", 20'd777, {BL, BL, BL, BL, BL, S7, S7, S7});
    dif.frequency = 20'd42;
    repeat (5) tick();
    rst_n = 1'b0;
    #2;
    check("mid rst AN", dif.AN, 8'hFF);
    check("mid rst SEG", dif.SEG, 7'h7F);
    check("mid rst DP", dif.DP, 1'b1);
    check("mid rst busy", dif.busy, 1'b0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("post rst AN", dif.AN, 8'hFE);
    check("post rst SEG", dif.SEG, S0);
    check("post rst busy", dif.busy, 1'b1);
    wait_idle("post rst");
    repeat (2) tick();
    capture("v42", {BL, BL, BL, BL, BL, BL, S4, S2});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
